iic_arbiter: RTL

- Shares one IIC_CTL bus controller among NUM_PORTS independent requesters, e.g. the RBCP-to-I2C bridge and the power-on clock/mux init sequencer.
- Performs round-robin arbitration and forwards the winner's command fields to IIC_CTL.
- Steers IIC_CTL's per-transaction responses (ack, write-data ack, read data valid, error, busy) back to the granted requester only.

---
 rtl/iic_arbiter.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/iic_arbiter.sv
// rtl/iic_arbiter.sv - round-robin arbiter sharing one IIC_CTL among NUM_PORTS requesters
module iic_arbiter #(
  parameter int NUM_PORTS = 2
) (
  input  logic                   CLK_IN,
  input  logic                   RESET_IN,
  input  logic [NUM_PORTS-1:0]   S_REQ_IN,
  input  logic [8*NUM_PORTS-1:0] S_NUM_IN,
  input  logic [7*NUM_PORTS-1:0] S_DAD_IN,
  input  logic [NUM_PORTS-1:0]   S_NOA_IN,
  input  logic [8*NUM_PORTS-1:0] S_ADR_IN,
  input  logic [NUM_PORTS-1:0]   S_RNW_IN,
  input  logic [8*NUM_PORTS-1:0] S_WDT_IN,
  output logic [NUM_PORTS-1:0]   S_RAK_OUT,
  output logic [NUM_PORTS-1:0]   S_WDA_OUT,
  output logic [NUM_PORTS-1:0]   S_WAE_OUT,
  output logic [NUM_PORTS-1:0]   S_BSY_OUT,
  output logic [7:0]             S_RDT_OUT,
  output logic [NUM_PORTS-1:0]   S_RVL_OUT,
  output logic [NUM_PORTS-1:0]   S_EOR_OUT,
  output logic [NUM_PORTS-1:0]   S_ERR_OUT,
  output logic                   M_REQ_OUT,
  output logic [7:0]             M_NUM_OUT,
  output logic [6:0]             M_DAD_OUT,
  output logic                   M_NOA_OUT,
  output logic [7:0]             M_ADR_OUT,
  output logic                   M_RNW_OUT,
  output logic [7:0]             M_WDT_OUT,
  input  logic                   M_RAK_IN,
  input  logic                   M_WDA_IN,
  input  logic                   M_WAE_IN,
  input  logic                   M_BSY_IN,
  input  logic [7:0]             M_RDT_IN,
  input  logic                   M_RVL_IN,
  input  logic                   M_EOR_IN,
  input  logic                   M_ERR_IN
);

  localparam int GW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_BUSY} state_t;

  state_t               state;
  state_t               state_nxt;
  logic [GW-1:0]        gnt;
  logic [GW-1:0]        last;
  logic [GW-1:0]        winner;
  logic                 has_winner;
  logic                 grant_go;
  logic [NUM_PORTS-1:0] pending;
  logic [NUM_PORTS-1:0] s_rak;
  logic [NUM_PORTS-1:0] s_bsy;
  logic [NUM_PORTS-1:0] s_err;
  logic                 m_req;
  logic [7:0]           m_num;
  logic [6:0]           m_dad;
  logic                 m_noa;
  logic [7:0]           m_adr;
  logic                 m_rnw;

  // A port whose acknowledge is on the wire this cycle is not a new request
  assign pending  = S_REQ_IN & ~s_rak;
  assign grant_go = (state == ST_IDLE) && has_winner && !M_BSY_IN;

  // Round-robin search: closest requesting port after the last one served
  always_comb begin
    int idx;
    idx        = 0;
    winner     = last;
    has_winner = 1'b0;
    for (int k = NUM_PORTS; k >= 1; k--) begin
      idx = (int'(last) + k) % NUM_PORTS;
      if (pending[GW'(idx)]) begin
        winner     = GW'(idx);
        has_winner = 1'b1;
      end
    end
  end

  // State register
  always_ff @(posedge CLK_IN or posedge RESET_IN) begin
    if (RESET_IN) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Next-state: grant, wait for IIC_CTL acknowledge, wait for IIC_CTL idle
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (grant_go)  state_nxt = ST_ISSUE;
      ST_ISSUE: if (M_RAK_IN)  state_nxt = ST_BUSY;
      ST_BUSY:  if (!M_BSY_IN) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Registered grant bookkeeping and command fields latched on the grant edge
  always_ff @(posedge CLK_IN or posedge RESET_IN) begin
    if (RESET_IN) begin
      gnt   <= '0;
      last  <= GW'(NUM_PORTS - 1);
      s_rak <= '0;
      s_bsy <= '0;
      s_err <= '0;
      m_req <= 1'b0;
      m_num <= '0;
      m_dad <= '0;
      m_noa <= 1'b0;
      m_adr <= '0;
      m_rnw <= 1'b0;
    end else begin
      s_rak <= '0;
      case (state)
        ST_IDLE: begin
          if (grant_go) begin
            gnt           <= winner;
            m_req         <= 1'b1;
            m_num         <= S_NUM_IN[8*winner +: 8];
            m_dad         <= S_DAD_IN[7*winner +: 7];
            m_noa         <= S_NOA_IN[winner];
            m_adr         <= S_ADR_IN[8*winner +: 8];
            m_rnw         <= S_RNW_IN[winner];
            s_bsy[winner] <= 1'b1;
            s_err[winner] <= 1'b0;
          end
        end
        ST_ISSUE: begin
          if (M_ERR_IN) s_err[gnt] <= 1'b1;
          if (M_RAK_IN) begin
            m_req      <= 1'b0;
            s_rak[gnt] <= 1'b1;
          end
        end
        ST_BUSY: begin
          if (M_ERR_IN) s_err[gnt] <= 1'b1;
          if (!M_BSY_IN) begin
            s_bsy[gnt] <= 1'b0;
            last       <= gnt;
          end
        end
        default: ;
      endcase
    end
  end

  // Combinational response steering to the granted port and write-data mux
  always_comb begin
    S_WDA_OUT = '0;
    S_WAE_OUT = '0;
    S_RVL_OUT = '0;
    S_EOR_OUT = '0;
    if (state != ST_IDLE) begin
      S_WDA_OUT[gnt] = M_WDA_IN;
      S_WAE_OUT[gnt] = M_WAE_IN;
      S_RVL_OUT[gnt] = M_RVL_IN;
      S_EOR_OUT[gnt] = M_EOR_IN;
    end
    M_WDT_OUT = (state == ST_ISSUE) ? S_ADR_IN[8*gnt +: 8] : S_WDT_IN[8*gnt +: 8];
  end

  assign S_RAK_OUT = s_rak;
  assign S_BSY_OUT = s_bsy;
  assign S_ERR_OUT = s_err;
  assign S_RDT_OUT = M_RDT_IN;
  assign M_REQ_OUT = m_req;
  assign M_NUM_OUT = m_num;
  assign M_DAD_OUT = m_dad;
  assign M_NOA_OUT = m_noa;
  assign M_ADR_OUT = m_adr;
  assign M_RNW_OUT = m_rnw;

endmodule
